// File: rtl/fill_fsm.sv
// Streams the six-byte fill-screen command (7C 46 r g b 0A) to a byte-wide
// transmitter, one load strobe per byte, pacing on the transmitter's empty flag.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// init       | idle, waiting for start; done holds the last completion
// loadk      | byte k presented, ldtxdata strobed for one cycle
// waitloadk  | byte k held, gives the transmitter time to drop txempty
// waitsendk  | byte k held until txempty reports the byte has gone
// finish     | transfer complete, done set on the way back to init
module fill_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       txempty,
    output logic       done,
    output logic [7:0] txdata,
    output logic       ldtxdata
);

    typedef enum logic [4:0] {
        init,
        load0, waitload0, waitsend0,
        load1, waitload1, waitsend1,
        load2, waitload2, waitsend2,
        load3, waitload3, waitsend3,
        load4, waitload4, waitsend4,
        load5, waitload5, waitsend5,
        finish
    } state_t;

    localparam logic [7:0] byte_prefix = 8'h7C;
    localparam logic [7:0] byte_fill   = 8'h46;
    localparam logic [7:0] byte_term   = 8'h0A;

    state_t     state;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;

    // Outputs are registered alongside the state: each transition loads the
    // values belonging to the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= init;
            done     <= 1'b0;
            txdata   <= 8'h00;
            ldtxdata <= 1'b0;
            r_q      <= 8'h00;
            g_q      <= 8'h00;
            b_q      <= 8'h00;
        end else begin
            ldtxdata <= 1'b0;
            case (state)
                init: begin
                    if (start) begin
                        state    <= load0;
                        ldtxdata <= 1'b1;
                        txdata   <= byte_prefix;
                        done     <= 1'b0;
                        r_q      <= r;
                        g_q      <= g;
                        b_q      <= b;
                    end
                end

                load0:     state <= waitload0;
                waitload0: state <= waitsend0;
                waitsend0: begin
                    if (txempty) begin
                        state    <= load1;
                        ldtxdata <= 1'b1;
                        txdata   <= byte_fill;
                    end
                end

                load1:     state <= waitload1;
                waitload1: state <= waitsend1;
                waitsend1: begin
                    if (txempty) begin
                        state    <= load2;
                        ldtxdata <= 1'b1;
                        txdata   <= r_q;
                    end
                end

                load2:     state <= waitload2;
                waitload2: state <= waitsend2;
                waitsend2: begin
                    if (txempty) begin
                        state    <= load3;
                        ldtxdata <= 1'b1;
                        txdata   <= g_q;
                    end
                end

                load3:     state <= waitload3;
                waitload3: state <= waitsend3;
                waitsend3: begin
                    if (txempty) begin
                        state    <= load4;
                        ldtxdata <= 1'b1;
                        txdata   <= b_q;
                    end
                end

                load4:     state <= waitload4;
                waitload4: state <= waitsend4;
                waitsend4: begin
                    if (txempty) begin
                        state    <= load5;
                        ldtxdata <= 1'b1;
                        txdata   <= byte_term;
                    end
                end

                load5:     state <= waitload5;
                waitload5: state <= waitsend5;
                waitsend5: begin
                    if (txempty) begin
                        state  <= finish;
                        txdata <= 8'h00;
                    end
                end

                finish: begin
                    state <= init;
                    done  <= 1'b1;
                end

                default: begin
                    state  <= init;
                    txdata <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fill_fsm.sv
// Bench for fill_fsm: expected bytes are queued when a transfer is started and
// matched against the bytes the monitor sees strobed into the transmitter.
module tb_fill_fsm;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] r, g, b;
    logic       txempty;
    logic       done;
    logic [7:0] txdata;
    logic       ldtxdata;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         consec = 0;
    logic       prev_ld = 1'b0;

    fill_fsm dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .r        (r),
        .g        (g),
        .b        (b),
        .txempty  (txempty),
        .done     (done),
        .txdata   (txdata),
        .ldtxdata (ldtxdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ldtxdata === 1'b1) got_q.push_back(txdata);
        if (ldtxdata === 1'b1 && prev_ld === 1'b1) consec++;
        prev_ld = ldtxdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        exp_q.push_back(8'h7C);
        exp_q.push_back(8'h46);
        exp_q.push_back(rr);
        exp_q.push_back(gg);
        exp_q.push_back(bb);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        consec = 0;
    endtask

    task automatic test_reset();
        logic bad;
        reset_n = 1'b0; start = 1'b0; txempty = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;
        tick(); tick();
        total++;
        if ({done, ldtxdata, txdata} !== 10'h000) begin
            $display("FAIL reset_values: done=%b ld=%b txdata=%h, required 0 0 00", done, ldtxdata, txdata);
        end else pass_cnt++;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ldtxdata !== 1'b0 || txdata !== 8'h00 || done !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL idle_stays_init: activity seen with start=0, required none");
        else pass_cnt++;
        total++;
        if (got_q.size() != 0) $display("FAIL idle_no_strobe: %0d strobes, required 0", got_q.size());
        else pass_cnt++;
        clear_sb();
    endtask

    task automatic test_stepwise();
        logic [7:0] seq [6];
        logic       bad_ld, bad_hold;
        seq = '{8'h7C, 8'h46, 8'hFF, 8'hFF, 8'hFF, 8'h0A};
        r = 8'hFF; g = 8'hFF; b = 8'hFF; txempty = 1'b0;
        start = 1'b1;
        push_expected(r, g, b);
        tick();
        start = 1'b0;
        bad_ld = 1'b0; bad_hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (ldtxdata !== 1'b1 || txdata !== seq[k]) begin
                $display("FAIL step_load%0d: ld=%b txdata=%h, required 1 %h", k, ldtxdata, txdata, seq[k]);
            end else pass_cnt++;
            tick();
            if (ldtxdata !== 1'b0 || txdata !== seq[k]) bad_hold = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (ldtxdata !== 1'b0 || txdata !== seq[k] || done !== 1'b0) bad_ld = 1'b1;
            end
            txempty = 1'b1;
            tick();
            txempty = 1'b0;
        end
        total++;
        if (bad_hold) $display("FAIL step_waitload: byte not held or strobe repeated, required held without strobe");
        else pass_cnt++;
        total++;
        if (bad_ld) $display("FAIL step_waitsend_hold: left waitsend with txempty=0, required hold");
        else pass_cnt++;
        total++;
        if ({done, ldtxdata, txdata} !== 10'h000) begin
            $display("FAIL step_finish: done=%b ld=%b txdata=%h, required 0 0 00", done, ldtxdata, txdata);
        end else pass_cnt++;
        tick();
        total++;
        if (done !== 1'b1 || ldtxdata !== 1'b0 || txdata !== 8'h00) begin
            $display("FAIL step_done: done=%b ld=%b txdata=%h, required 1 0 00", done, ldtxdata, txdata);
        end else pass_cnt++;
        total++;
        if (got_q.size() != 6) $display("FAIL step_strobes: %0d strobes, required 6", got_q.size());
        else pass_cnt++;
        clear_sb();
    endtask

    task automatic run_and_check(input string name, input bit corrupt_colour);
        int n;
        logic [7:0] e, a;
        txempty = 1'b1;
        start = 1'b1;
        push_expected(r, g, b);
        tick();
        start = 1'b0;
        if (corrupt_colour) begin
            r = 8'h00; g = 8'h00; b = 8'h00;
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 19) $display("FAIL %s_done_latency: %0d edges, required 19", name, n);
        else pass_cnt++;
        total++;
        if (ldtxdata !== 1'b0 || txdata !== 8'h00) begin
            $display("FAIL %s_done_in_init: ld=%b txdata=%h, required 0 00", name, ldtxdata, txdata);
        end else pass_cnt++;
        total++;
        if (got_q.size() != 6) $display("FAIL %s_strobes: %0d strobes, required 6", name, got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            a = got_q.pop_front();
            total++;
            if (a !== e) $display("FAIL %s_byte%0d: got %h, required %h", name, i, a, e);
            else pass_cnt++;
        end
        total++;
        if (consec != 0) $display("FAIL %s_consecutive: %0d back-to-back strobes, required 0", name, consec);
        else pass_cnt++;
        clear_sb();
    endtask

    task automatic test_full_run();
        r = 8'h12; g = 8'h34; b = 8'h56;
        run_and_check("full", 1'b0);
    endtask

    task automatic test_colour_capture();
        r = 8'hAA; g = 8'hBB; b = 8'hCC;
        run_and_check("capture", 1'b1);
    endtask

    task automatic test_ignored_start();
        int n;
        logic bad;
        logic [7:0] e, a;
        r = 8'h21; g = 8'h43; b = 8'h65; txempty = 1'b0;
        start = 1'b1;
        push_expected(r, g, b);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(); tick();
            txempty = 1'b1;
            tick();
            txempty = 1'b0;
        end
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (ldtxdata !== 1'b0 || txdata !== 8'h21) begin
            $display("FAIL ign_busy_start: ld=%b txdata=%h, required 0 21", ldtxdata, txdata);
        end else pass_cnt++;
        txempty = 1'b1;
        n = 0;
        while (txdata !== 8'h00 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (txdata !== 8'h00 || done !== 1'b0) begin
            $display("FAIL ign_reach_finish: txdata=%h done=%b, required 00 0", txdata, done);
        end else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || ldtxdata !== 1'b0) begin
            $display("FAIL ign_finish_start: done=%b ld=%b, required 1 0", done, ldtxdata);
        end else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ldtxdata !== 1'b0 || done !== 1'b1) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL ign_no_queue: transfer began without start in init, required idle");
        else pass_cnt++;
        total++;
        if (got_q.size() != 6) $display("FAIL ign_strobes: %0d strobes, required 6", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            a = got_q.pop_front();
            total++;
            if (a !== e) $display("FAIL ign_byte%0d: got %h, required %h", i, a, e);
            else pass_cnt++;
        end
        clear_sb();
        start = 1'b1;
        push_expected(r, g, b);
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b0 || ldtxdata !== 1'b1 || txdata !== 8'h7C) begin
            $display("FAIL restart: done=%b ld=%b txdata=%h, required 0 1 7c", done, ldtxdata, txdata);
        end else pass_cnt++;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != 19 || got_q.size() != 6) begin
            $display("FAIL restart_complete: %0d edges %0d strobes, required 19 6", n, got_q.size());
        end else pass_cnt++;
        clear_sb();
    endtask

    task automatic test_mid_reset();
        logic bad;
        r = 8'h9A; g = 8'hBC; b = 8'hDE; txempty = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (ldtxdata !== 1'b0 || txdata !== 8'hBC) begin
            $display("FAIL mid_waitload3: ld=%b txdata=%h, required 0 bc", ldtxdata, txdata);
        end else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({done, ldtxdata, txdata} !== 10'h000) begin
            $display("FAIL mid_reset: done=%b ld=%b txdata=%h, required 0 0 00", done, ldtxdata, txdata);
        end else pass_cnt++;
        tick();
        reset_n = 1'b1;
        clear_sb();
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done !== 1'b0 || ldtxdata !== 1'b0 || txdata !== 8'h00) bad = 1'b1;
        end
        total++;
        if (bad || got_q.size() != 0) $display("FAIL mid_abort: transfer resumed after reset, required idle");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stepwise();
        test_full_run();
        test_colour_capture();
        test_ignored_start();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
